// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator: mode encodings,
// default timing parameters and the sequencer state type.
package spi_pkg;

    // SPI modes encoded as {cpol, cpha}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Defaults: 25 system clocks per SCLK half-period, 32-bit transfers.
    localparam int SPI_DIV_HALF_DEF = 25;
    localparam int SPI_MAX_BITS_DEF = 32;

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_half_cnt.sv
// Half-period prescaler: counts 0..DIV_HALF-1 while enabled and flags the
// terminal count. A clear forces the count to zero and suppresses tc.
module spi_half_cnt
    import spi_pkg::*;
#(
    parameter int DIV_HALF = SPI_DIV_HALF_DEF,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DIV_HALF - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count is only meaningful while counting and not being cleared.
    assign tc = en && !clr && (cnt_q == TC_VAL);

    // Next count: clear wins, then wrap at terminal count, else increment.
    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : spi_half_cnt

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock and edge-strobe generator. Sequences one transfer of
// nbits bits: leading/trailing SCLK edges every DIV_HALF clocks, mode-dependent
// sample/shift strobes, a one-half-period CS hold guard, then done.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter  int DIV_HALF = SPI_DIV_HALF_DEF,
    parameter  int CNT_W    = 16,
    parameter  int MAX_BITS = SPI_MAX_BITS_DEF,
    localparam int BIT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [BIT_W-1:0] nbits,
    output logic             sclk,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             load_stb,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             done
);

    spi_state_e       state_q, state_d;
    logic             sclk_q, sclk_d;
    logic             lead_q, lead_d;
    logic             trail_q, trail_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             load_q, load_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0] nbits_q, nbits_d;
    logic [1:0]       mode_q, mode_d;
    // phase_q=0: next SCLK edge is a leading edge; 1: trailing edge.
    logic             phase_q, phase_d;
    // Zero-length transfer accepted; done is due on the next edge.
    logic             zero_q, zero_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic             half_tc;
    logic             last_bit;

    spi_half_cnt #(
        .DIV_HALF (DIV_HALF),
        .CNT_W    (CNT_W)
    ) u_half_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (half_tc)
    );

    // The trailing edge about to fire completes the final bit.
    assign last_bit = (bit_cnt_q + BIT_W'(1)) == nbits_q;

    // Sequencer: next state, SCLK level, strobes and counters.
    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        lead_d    = 1'b0;
        trail_d   = 1'b0;
        sample_d  = 1'b0;
        shift_d   = 1'b0;
        load_d    = 1'b0;
        done_d    = 1'b0;
        busy_d    = busy_q;
        bit_cnt_d = bit_cnt_q;
        nbits_d   = nbits_q;
        mode_d    = mode_q;
        phase_d   = phase_q;
        zero_d    = zero_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sclk_d  = cpol;
                cnt_clr = 1'b1;
                if (abort) begin
                    zero_d = 1'b0;
                end else if (zero_q) begin
                    // Finishing a zero-length transfer; start is not accepted here.
                    zero_d = 1'b0;
                    done_d = 1'b1;
                end else if (start) begin
                    mode_d    = {cpol, cpha};
                    nbits_d   = nbits;
                    load_d    = 1'b1;
                    bit_cnt_d = '0;
                    phase_d   = 1'b0;
                    if (nbits == '0) begin
                        zero_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                cnt_en = 1'b1;
                if (abort) begin
                    cnt_clr = 1'b1;
                    sclk_d  = cpol;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (half_tc) begin
                    sclk_d  = ~sclk_q;
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        lead_d = 1'b1;
                        case (mode_q)
                            SPI_MODE0, SPI_MODE2: sample_d = 1'b1;
                            default:              shift_d  = 1'b1;
                        endcase
                    end else begin
                        trail_d   = 1'b1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        case (mode_q)
                            SPI_MODE1, SPI_MODE3: sample_d = 1'b1;
                            default:              shift_d  = !last_bit;
                        endcase
                        if (last_bit) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end

            ST_HOLD: begin
                cnt_en = 1'b1;
                sclk_d = mode_q[1];
                if (abort) begin
                    cnt_clr = 1'b1;
                    sclk_d  = cpol;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (half_tc) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sclk_q    <= 1'b0;
            lead_q    <= 1'b0;
            trail_q   <= 1'b0;
            sample_q  <= 1'b0;
            shift_q   <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            nbits_q   <= '0;
            mode_q    <= '0;
            phase_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            lead_q    <= lead_d;
            trail_q   <= trail_d;
            sample_q  <= sample_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            bit_cnt_q <= bit_cnt_d;
            nbits_q   <= nbits_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            zero_q    <= zero_d;
        end
    end

    assign sclk       = sclk_q;
    assign lead_stb   = lead_q;
    assign trail_stb  = trail_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;
    assign load_stb   = load_q;
    assign bit_cnt    = bit_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : spi_sclk_gen

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: two instances (half-period 25 and 1),
// a scoreboard of expected strobe events per cycle, plus level spot checks.
module tb_spi_sclk_gen;

    localparam int B_LOAD   = 5;
    localparam int B_LEAD   = 4;
    localparam int B_TRAIL  = 3;
    localparam int B_SAMPLE = 2;
    localparam int B_SHIFT  = 1;
    localparam int B_DONE   = 0;

    typedef struct {
        int         id;
        int         cyc;
        logic [5:0] vec;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic       abort;
    logic       cpol;
    logic       cpha;
    logic [5:0] nbits;

    logic [1:0] sclk, lead, trail, sample, shift, load, busy, done;
    logic [5:0] bit_cnt0, bit_cnt1;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;
    int   shift_cnt [2];
    ev_t  sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_sclk_gen #(.DIV_HALF(25), .CNT_W(16), .MAX_BITS(32)) u_dut25 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort),
        .cpol(cpol), .cpha(cpha), .nbits(nbits),
        .sclk(sclk[0]), .lead_stb(lead[0]), .trail_stb(trail[0]),
        .sample_stb(sample[0]), .shift_stb(shift[0]), .load_stb(load[0]),
        .bit_cnt(bit_cnt0), .busy(busy[0]), .done(done[0])
    );

    spi_sclk_gen #(.DIV_HALF(1), .CNT_W(16), .MAX_BITS(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort),
        .cpol(cpol), .cpha(cpha), .nbits(nbits),
        .sclk(sclk[1]), .lead_stb(lead[1]), .trail_stb(trail[1]),
        .sample_stb(sample[1]), .shift_stb(shift[1]), .load_stb(load[1]),
        .bit_cnt(bit_cnt1), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int id, input int c, input logic [5:0] v);
        ev_t e;
        e.id  = id;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Expected strobe timeline of one transfer; abort_after<0 means run to done.
    task automatic push_xfer(input int id, input int e0, input int d, input logic pha,
                             input int n, input int abort_after);
        logic [5:0] v;
        v = '0;
        v[B_LOAD] = 1'b1;
        push_ev(id, e0, v);
        if (n == 0) begin
            v = '0;
            v[B_DONE] = 1'b1;
            push_ev(id, e0 + 1, v);
        end else begin
            for (int k = 1; k <= 2 * n; k++) begin
                if (abort_after >= 0 && k > abort_after) break;
                v = '0;
                if (k % 2 == 1) begin
                    v[B_LEAD] = 1'b1;
                    if (pha) v[B_SHIFT] = 1'b1; else v[B_SAMPLE] = 1'b1;
                end else begin
                    v[B_TRAIL] = 1'b1;
                    if (pha) v[B_SAMPLE] = 1'b1;
                    else if (k != 2 * n) v[B_SHIFT] = 1'b1;
                end
                push_ev(id, e0 + k * d, v);
            end
            if (abort_after < 0) begin
                v = '0;
                v[B_DONE] = 1'b1;
                push_ev(id, e0 + (2 * n + 1) * d, v);
            end
        end
    endtask

    // Advance to the next falling edge and compare strobes against the scoreboard.
    task automatic tick();
        logic [5:0] obs [2];
        ev_t        ev;
        @(negedge clk);
        obs[0] = {load[0], lead[0], trail[0], sample[0], shift[0], done[0]};
        obs[1] = {load[1], lead[1], trail[1], sample[1], shift[1], done[1]};
        for (int id = 0; id < 2; id++) begin
            if (sb.size() > 0 && sb[0].id == id && sb[0].cyc < cyc) begin
                ev = sb.pop_front();
                check($sformatf("missed_ev%0d", id), 32'(cyc), 32'(ev.cyc));
            end
            if (sb.size() > 0 && sb[0].id == id && sb[0].cyc == cyc) begin
                ev = sb.pop_front();
                check($sformatf("strobes%0d@%0d", id, cyc), 32'(obs[id]), 32'(ev.vec));
            end else if (obs[id] != '0) begin
                check($sformatf("stray%0d@%0d", id, cyc), 32'(obs[id]), 32'd0);
            end
            if (obs[id][B_SHIFT]) shift_cnt[id]++;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic start_xfer(input int id, input logic pol, input logic pha, input int n,
                              input int abort_after, output int e0);
        cpol      = pol;
        cpha      = pha;
        nbits     = 6'(n);
        start[id] = 1'b1;
        e0        = cyc + 1;
        push_xfer(id, e0, (id == 0) ? 25 : 1, pha, n, abort_after);
        tick();
        start[id] = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({sclk, lead, trail, sample, shift, load, busy, done, bit_cnt0, bit_cnt1}), 32'd0);
    endtask

    initial begin
        int e;
        int e2;
        rst_n = 1'b0;
        start = '0;
        abort = 1'b0;
        cpol  = 1'b0;
        cpha  = 1'b0;
        nbits = '0;
        shift_cnt[0] = 0;
        shift_cnt[1] = 0;

        // Reset state.
        #23;
        check_quiet("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_sclk0", 32'(sclk), 32'd0);

        // Mode 0, 8 bits, half-period 25.
        start_xfer(0, 1'b0, 1'b0, 8, -1, e);
        check("m0_busy_e0", 32'(busy[0]), 32'd1);
        check("m0_bitcnt_e0", 32'(bit_cnt0), 32'd0);
        run_to(e + 24);
        check("m0_sclk_pre", 32'(sclk[0]), 32'd0);
        run_to(e + 25);
        check("m0_sclk_lead1", 32'(sclk[0]), 32'd1);
        run_to(e + 50);
        check("m0_sclk_trail1", 32'(sclk[0]), 32'd0);
        check("m0_bitcnt_1", 32'(bit_cnt0), 32'd1);
        run_to(e + 400);
        check("m0_bitcnt_8", 32'(bit_cnt0), 32'd8);
        check("m0_busy_hold", 32'(busy[0]), 32'd1);
        run_to(e + 425);
        check("m0_busy_done", 32'(busy[0]), 32'd0);
        run_to(e + 430);
        check("m0_sclk_idle", 32'(sclk[0]), 32'd0);
        check("m0_shift_count", 32'(shift_cnt[0]), 32'd7);
        check("m0_sb_empty", 32'(sb.size()), 32'd0);

        // Mode 3, 4 bits, half-period 1.
        cpol = 1'b1;
        tick();
        tick();
        check("m3_sclk_idle1", 32'(sclk[1]), 32'd1);
        shift_cnt[1] = 0;
        start_xfer(1, 1'b1, 1'b1, 4, -1, e);
        run_to(e + 1);
        check("m3_sclk_lead1", 32'(sclk[1]), 32'd0);
        run_to(e + 8);
        check("m3_bitcnt_4", 32'(bit_cnt1), 32'd4);
        run_to(e + 9);
        check("m3_busy_done", 32'(busy[1]), 32'd0);
        run_to(e + 12);
        check("m3_sclk_after", 32'(sclk[1]), 32'd1);
        check("m3_shift_count", 32'(shift_cnt[1]), 32'd4);

        // Zero-length transfer.
        cpol = 1'b0;
        tick();
        tick();
        start_xfer(0, 1'b0, 1'b0, 0, -1, e);
        check("z_busy_e0", 32'(busy[0]), 32'd0);
        check("z_sclk_e0", 32'(sclk[0]), 32'd0);
        tick();
        check("z_busy_e1", 32'(busy[0]), 32'd0);
        run_to(e + 5);
        check("z_sclk_after", 32'(sclk[0]), 32'd0);

        // Mode 1, 8 bits, abort after edge 5.
        start_xfer(0, 1'b0, 1'b1, 8, 5, e);
        run_to(e + 125);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy[0]), 32'd0);
        check("ab_sclk", 32'(sclk[0]), 32'd0);
        check("ab_bitcnt", 32'(bit_cnt0), 32'd2);
        run_to(e + 430);
        check("ab_bitcnt_held", 32'(bit_cnt0), 32'd2);
        check("ab_sb_empty", 32'(sb.size()), 32'd0);

        // Abort together with start in idle: start dropped.
        nbits    = 6'd8;
        start[0] = 1'b1;
        abort    = 1'b1;
        tick();
        start[0] = 1'b0;
        abort    = 1'b0;
        check("abst_load", 32'(load[0]), 32'd0);
        check("abst_busy", 32'(busy[0]), 32'd0);
        tick();
        check("abst_busy2", 32'(busy[0]), 32'd0);

        // Start re-pulsed and cpol/cpha/nbits changed while busy; restart in done cycle.
        start_xfer(0, 1'b0, 1'b0, 2, -1, e);
        run_to(e + 30);
        start[0] = 1'b1;
        cpol     = 1'b1;
        cpha     = 1'b1;
        nbits    = 6'd5;
        tick();
        start[0] = 1'b0;
        run_to(e + 100);
        check("bz_sclk_last", 32'(sclk[0]), 32'd0);
        check("bz_bitcnt", 32'(bit_cnt0), 32'd2);
        run_to(e + 124);
        check("bz_sclk_hold", 32'(sclk[0]), 32'd0);
        check("bz_busy_hold", 32'(busy[0]), 32'd1);
        run_to(e + 125);
        check("bz_busy_done", 32'(busy[0]), 32'd0);
        start_xfer(0, 1'b1, 1'b0, 1, -1, e2);
        check("rs_e0_offset", 32'(e2 - e), 32'd126);
        check("rs_sclk_e0", 32'(sclk[0]), 32'd1);
        check("rs_busy_e0", 32'(busy[0]), 32'd1);
        run_to(e2 + 25);
        check("rs_sclk_lead", 32'(sclk[0]), 32'd0);
        run_to(e2 + 50);
        check("rs_sclk_trail", 32'(sclk[0]), 32'd1);
        check("rs_bitcnt", 32'(bit_cnt0), 32'd1);
        run_to(e2 + 80);
        check("rs_busy_after", 32'(busy[0]), 32'd0);
        check("rs_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of a transfer.
        start_xfer(0, 1'b0, 1'b0, 8, -1, e);
        run_to(e + 60);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("rst_mid_async");
        sb.delete();
        @(posedge clk);
        #1;
        check_quiet("rst_mid_held");
        @(negedge clk);
        cpol  = 1'b1;
        rst_n = 1'b1;
        tick();
        check("rst_sclk_track", 32'(sclk), 32'd3);
        check("rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_spi_sclk_gen
